cpu_decode_stage: RTL and testbench
===================================

CPU_DECODE_STAGE -- requirements
Module: cpu_decode_stage

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, meaning register-bank address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data/instruction width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports if_valid  input  1, if_instr  input  DATA_WIDTH, if_pc  input  DATA_WIDTH  fetch handshake and payload.
REQ-006 SHALL have port if_ready  output  1  decode accepts the fetch payload this cycle.
REQ-007 SHALL have ports a1, a2  output  ADDR_WIDTH  register-bank read addresses; rd1, rd2  input  DATA_WIDTH  read data.
REQ-008 SHALL have ports wb_wen  input  1, wb_addr  input  ADDR_WIDTH, wb_data  input  DATA_WIDTH  copy of the register-bank write port.
REQ-009 SHALL have port flush  input  1  discard the current and held instruction.
REQ-010 SHALL have ports ex_valid  output  1, ex_ready  input  1  execute handshake.
REQ-011 SHALL have outputs ex_pc, ex_rs1_val, ex_rs2_val, ex_imm (DATA_WIDTH); ex_rd, ex_rs1, ex_rs2 (ADDR_WIDTH); ex_opcode 7; ex_funct3 3; ex_funct7 7; ex_is_load 1; ex_illegal 1.
REQ-012 SHALL have port stall_cnt  output  16  saturating count of load-use bubble cycles.

Function
REQ-013 SHALL drive a1 = if_instr[19:15], a2 = if_instr[24:20] combinationally.
REQ-014 SHALL bypass: operand = wb_data when wb_wen && wb_addr == aN && aN != 0; else rdN; aN == 0 always yields 0.
REQ-015 SHALL compute hazard = ex_valid && ex_is_load && ex_rd != 0 && (ex_rd == a1 || ex_rd == a2).
REQ-016 SHALL drive if_ready = (!ex_valid || ex_ready) && !hazard && !flush.
REQ-017 SHALL register payload on if_valid && if_ready; ex_valid set next cycle; latency 1 cycle.
REQ-018 SHALL hold all ex_* outputs stable while ex_valid && !ex_ready.
REQ-019 SHALL, when hazard && ex_ready, clear ex_valid next cycle (one bubble), increment stall_cnt (saturate at 0xFFFF), and accept the stalled instruction the following cycle with bypassed operands.
REQ-020 SHALL clear ex_valid next cycle when flush is high, regardless of ex_ready or hazard; flush has priority over accept and stall.
REQ-021 SHALL clear ex_valid next cycle when ex_ready && !(if_valid && if_ready).
REQ-022 SHALL generate ex_imm sign-extended: I for opcodes 0010011/0000011/1100111/1110011, S for 0100011, B for 1100011 (bit0 = 0), U for 0110111/0010111 (low 12 bits = 0), J for 1101111 (bit0 = 0), 0 for 0110011.
REQ-023 SHALL set ex_illegal for any opcode outside REQ-022 list or instr[1:0] != 2'b11; ex_imm = 0 then.
REQ-024 SHALL set ex_is_load = (opcode == 0000011).

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear ex_valid, stall_cnt and all ex_* outputs to 0.
REQ-026 SHALL hold if_ready low while rst_n low; first accept possible on the first edge after release.

Structure
REQ-027 SHALL take opcode constants and an immediate-type enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE) from pkg_cpu_typedefs.
REQ-028 SHALL place immediate generation and illegal detection in one combinational sub-module cpu_imm_gen.

Verification
REQ-029 Reset then addi x5,x0,7 (0x00700293) with ex_ready=1 -> next cycle ex_valid=1, ex_rd=5, ex_imm=7, ex_rs1_val=0.
REQ-030 rd1=0x11 while wb_wen=1, wb_addr=a1=3, wb_data=0xAB -> ex_rs1_val=0xAB; same with wb_addr=0 bypass suppressed for a1=0 -> 0.
REQ-031 lw x6 accepted, next if_instr add x7,x6,x1 -> if_ready=0 one cycle, ex_valid=0 bubble, stall_cnt=1, add accepted next cycle.
REQ-032 ex_ready=0 for 3 cycles with ex_valid=1 -> all ex_* unchanged, if_ready=0; flush asserted -> ex_valid=0 next cycle.
REQ-033 beq with imm=-4 (0xFE000EE3) -> ex_imm=0xFFFFFFFC; instr 0x0000007F -> ex_illegal=1, ex_imm=0.

Source files
------------

// File: rtl/pkg_cpu_typedefs.sv
// rtl/pkg_cpu_typedefs.sv - opcode constants and immediate-format enum for the decode stage
package pkg_cpu_typedefs;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

endpackage

// File: rtl/cpu_imm_gen.sv
// rtl/cpu_imm_gen.sv - immediate extraction and illegal-opcode detection (combinational)
module cpu_imm_gen
    import pkg_cpu_typedefs::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] imm,
    output logic                  illegal
);

    imm_type_e   w_type;
    logic        w_known;
    logic [31:0] w_imm32;

    always_comb begin
        w_type  = IMM_NONE;
        w_known = 1'b1;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: w_type = IMM_I;
            OP_STORE:                            w_type = IMM_S;
            OP_BRANCH:                           w_type = IMM_B;
            OP_LUI, OP_AUIPC:                    w_type = IMM_U;
            OP_JAL:                              w_type = IMM_J;
            OP_REG:                              w_type = IMM_NONE;
            default:                             w_known = 1'b0;
        endcase
    end

    assign illegal = !w_known || (instr[1:0] != 2'b11);

    always_comb begin
        w_imm32 = 32'd0;
        if (!illegal) begin
            case (w_type)
                IMM_I:   w_imm32 = {{20{instr[31]}}, instr[31:20]};
                IMM_S:   w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                IMM_B:   w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                IMM_U:   w_imm32 = {instr[31:12], 12'd0};
                IMM_J:   w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                default: w_imm32 = 32'd0;
            endcase
        end
    end

    assign imm = DATA_WIDTH'($signed(w_imm32));

endmodule

// File: rtl/cpu_decode_stage.sv
// rtl/cpu_decode_stage.sv - decode pipeline stage with operand bypass and load-use stall
module cpu_decode_stage
    import pkg_cpu_typedefs::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_valid,
    input  logic [DATA_WIDTH-1:0] if_instr,
    input  logic [DATA_WIDTH-1:0] if_pc,
    output logic                  if_ready,
    output logic [ADDR_WIDTH-1:0] a1,
    output logic [ADDR_WIDTH-1:0] a2,
    input  logic [DATA_WIDTH-1:0] rd1,
    input  logic [DATA_WIDTH-1:0] rd2,
    input  logic                  wb_wen,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  flush,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [DATA_WIDTH-1:0] ex_pc,
    output logic [DATA_WIDTH-1:0] ex_rs1_val,
    output logic [DATA_WIDTH-1:0] ex_rs2_val,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [ADDR_WIDTH-1:0] ex_rd,
    output logic [ADDR_WIDTH-1:0] ex_rs1,
    output logic [ADDR_WIDTH-1:0] ex_rs2,
    output logic [6:0]            ex_opcode,
    output logic [2:0]            ex_funct3,
    output logic [6:0]            ex_funct7,
    output logic                  ex_is_load,
    output logic                  ex_illegal,
    output logic [15:0]           stall_cnt
);

    logic [DATA_WIDTH-1:0] w_op1;
    logic [DATA_WIDTH-1:0] w_op2;
    logic [DATA_WIDTH-1:0] w_imm;
    logic                  w_illegal;
    logic                  w_hazard;
    logic                  w_accept;

    assign a1 = if_instr[15 +: ADDR_WIDTH];
    assign a2 = if_instr[20 +: ADDR_WIDTH];

    // x0 reads as zero even if the write port targets it
    assign w_op1 = (a1 == '0) ? '0 : ((wb_wen && wb_addr == a1) ? wb_data : rd1);
    assign w_op2 = (a2 == '0) ? '0 : ((wb_wen && wb_addr == a2) ? wb_data : rd2);

    assign w_hazard = ex_valid && ex_is_load && (ex_rd != '0) && ((ex_rd == a1) || (ex_rd == a2));
    assign if_ready = rst_n && (!ex_valid || ex_ready) && !w_hazard && !flush;
    assign w_accept = if_valid && if_ready;

    cpu_imm_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imm_gen (
        .instr   (if_instr),
        .imm     (w_imm),
        .illegal (w_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_rs1_val <= '0;
            ex_rs2_val <= '0;
            ex_imm     <= '0;
            ex_rd      <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_opcode  <= '0;
            ex_funct3  <= '0;
            ex_funct7  <= '0;
            ex_is_load <= 1'b0;
            ex_illegal <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (w_accept) begin
                ex_valid   <= 1'b1;
                ex_pc      <= if_pc;
                ex_rs1_val <= w_op1;
                ex_rs2_val <= w_op2;
                ex_imm     <= w_imm;
                ex_rd      <= if_instr[7 +: ADDR_WIDTH];
                ex_rs1     <= a1;
                ex_rs2     <= a2;
                ex_opcode  <= if_instr[6:0];
                ex_funct3  <= if_instr[14:12];
                ex_funct7  <= if_instr[31:25];
                ex_is_load <= (if_instr[6:0] == OP_LOAD);
                ex_illegal <= w_illegal;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
            if (!flush && w_hazard && ex_ready && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_decode_stage.sv
// tb/tb_cpu_decode_stage.sv - directed table-driven bench for cpu_decode_stage
module tb_cpu_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        wb_wen;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_val;
    logic [31:0] ex_rs2_val;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        ex_is_load;
    logic        ex_illegal;
    logic [15:0] stall_cnt;

    cpu_decode_stage #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_ready   (if_ready),
        .a1         (a1),
        .a2         (a2),
        .rd1        (rd1),
        .rd2        (rd2),
        .wb_wen     (wb_wen),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_pc      (ex_pc),
        .ex_rs1_val (ex_rs1_val),
        .ex_rs2_val (ex_rs2_val),
        .ex_imm     (ex_imm),
        .ex_rd      (ex_rd),
        .ex_rs1     (ex_rs1),
        .ex_rs2     (ex_rs2),
        .ex_opcode  (ex_opcode),
        .ex_funct3  (ex_funct3),
        .ex_funct7  (ex_funct7),
        .ex_is_load (ex_is_load),
        .ex_illegal (ex_illegal),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        wb_wen;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [4:0]  exp_rd;
        logic [31:0] exp_rs1_val;
        logic [31:0] exp_rs2_val;
        logic [31:0] exp_imm;
        logic        exp_illegal;
        logic        exp_is_load;
    } vec_t;

    vec_t vecs [11];
    int   n_tests;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_valid = 1'b0;
        wb_wen   = 1'b0;
        wb_addr  = 5'd0;
        wb_data  = 32'd0;
        flush    = 1'b0;
        ex_ready = 1'b1;
    endtask

    logic [31:0] held_pc;
    logic [4:0]  held_rd;
    logic [31:0] held_imm;

    initial begin
        n_tests = 0;
        n_fail  = 0;

        //          instr          rd1           rd2           wen   waddr  wdata         rd     rs1_val       rs2_val       imm           ill   load
        vecs[0]  = '{32'h00700293, 32'h00000055, 32'h00000099, 1'b0, 5'd0,  32'h0,        5'd5,  32'h0,        32'h00000099, 32'h00000007, 1'b0, 1'b0};
        vecs[1]  = '{32'h00018093, 32'h00000011, 32'h00000022, 1'b1, 5'd3,  32'h000000AB, 5'd1,  32'h000000AB, 32'h0,        32'h0,        1'b0, 1'b0};
        vecs[2]  = '{32'h00000093, 32'h00000011, 32'h00000022, 1'b1, 5'd0,  32'h000000AB, 5'd1,  32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
        vecs[3]  = '{32'h001303B3, 32'h00000100, 32'h00000200, 1'b0, 5'd0,  32'h0,        5'd7,  32'h00000100, 32'h00000200, 32'h0,        1'b0, 1'b0};
        vecs[4]  = '{32'h0020A423, 32'h00001000, 32'h00002222, 1'b1, 5'd2,  32'h00003333, 5'd8,  32'h00001000, 32'h00003333, 32'h00000008, 1'b0, 1'b0};
        vecs[5]  = '{32'hFE000EE3, 32'h00000001, 32'h00000002, 1'b0, 5'd0,  32'h0,        5'd29, 32'h0,        32'h0,        32'hFFFFFFFC, 1'b0, 1'b0};
        vecs[6]  = '{32'h0000007F, 32'h00000001, 32'h00000002, 1'b0, 5'd0,  32'h0,        5'd0,  32'h0,        32'h0,        32'h0,        1'b1, 1'b0};
        vecs[7]  = '{32'h12345537, 32'h00000077, 32'h00000088, 1'b0, 5'd0,  32'h0,        5'd10, 32'h00000077, 32'h00000088, 32'h12345000, 1'b0, 1'b0};
        vecs[8]  = '{32'hFF9FF0EF, 32'h00000001, 32'h00000002, 1'b0, 5'd0,  32'h0,        5'd1,  32'h00000001, 32'h00000002, 32'hFFFFFFF8, 1'b0, 1'b0};
        vecs[9]  = '{32'h00412303, 32'h00000010, 32'h00000020, 1'b0, 5'd0,  32'h0,        5'd6,  32'h00000010, 32'h00000020, 32'h00000004, 1'b0, 1'b1};
        vecs[10] = '{32'h00700290, 32'h00000001, 32'h00000005, 1'b0, 5'd0,  32'h0,        5'd5,  32'h0,        32'h00000005, 32'h0,        1'b1, 1'b0};

        rst_n    = 1'b0;
        idle_inputs();
        if_valid = 1'b1;
        if_instr = 32'h00700293;
        if_pc    = 32'h00000100;
        rd1      = 32'd0;
        rd2      = 32'd0;
        #3;
        check("reset_if_ready", {31'd0, if_ready}, 32'd0);
        check("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check("reset_ex_pc", ex_pc, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        idle_inputs();

        for (int i = 0; i < 11; i++) begin
            if_valid = 1'b1;
            if_instr = vecs[i].instr;
            if_pc    = 32'h00001000 + 32'(i * 4);
            rd1      = vecs[i].rd1;
            rd2      = vecs[i].rd2;
            wb_wen   = vecs[i].wb_wen;
            wb_addr  = vecs[i].wb_addr;
            wb_data  = vecs[i].wb_data;
            #1;
            check($sformatf("v%0d_if_ready", i), {31'd0, if_ready}, 32'd1);
            step();
            check($sformatf("v%0d_ex_valid", i), {31'd0, ex_valid}, 32'd1);
            check($sformatf("v%0d_ex_pc", i), ex_pc, 32'h00001000 + 32'(i * 4));
            check($sformatf("v%0d_ex_rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].exp_rd});
            check($sformatf("v%0d_rs1_val", i), ex_rs1_val, vecs[i].exp_rs1_val);
            check($sformatf("v%0d_rs2_val", i), ex_rs2_val, vecs[i].exp_rs2_val);
            check($sformatf("v%0d_imm", i), ex_imm, vecs[i].exp_imm);
            check($sformatf("v%0d_illegal", i), {31'd0, ex_illegal}, {31'd0, vecs[i].exp_illegal});
            check($sformatf("v%0d_is_load", i), {31'd0, ex_is_load}, {31'd0, vecs[i].exp_is_load});
            check($sformatf("v%0d_opcode", i), {25'd0, ex_opcode}, {25'd0, vecs[i].instr[6:0]});
            idle_inputs();
            step();
            check($sformatf("v%0d_drain", i), {31'd0, ex_valid}, 32'd0);
        end

        // load-use: lw x6 followed by add x7,x6,x1
        if_valid = 1'b1;
        if_instr = 32'h00412303;
        if_pc    = 32'h00002000;
        rd1      = 32'h10;
        rd2      = 32'h20;
        step();
        check("lu_load_valid", {31'd0, ex_valid}, 32'd1);
        if_instr = 32'h001303B3;
        if_pc    = 32'h00002004;
        rd1      = 32'h0;
        rd2      = 32'h00000111;
        #1;
        check("lu_if_ready_low", {31'd0, if_ready}, 32'd0);
        step();
        check("lu_bubble", {31'd0, ex_valid}, 32'd0);
        check("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        wb_wen  = 1'b1;
        wb_addr = 5'd6;
        wb_data = 32'h0000DEAD;
        #1;
        check("lu_if_ready_again", {31'd0, if_ready}, 32'd1);
        step();
        check("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        check("lu_add_rd", {27'd0, ex_rd}, 32'd7);
        check("lu_add_rs1_bypass", ex_rs1_val, 32'h0000DEAD);
        check("lu_add_rs2", ex_rs2_val, 32'h00000111);
        check("lu_add_pc", ex_pc, 32'h00002004);
        idle_inputs();
        step();
        check("lu_stall_cnt_hold", {16'd0, stall_cnt}, 32'd1);

        // back-pressure then flush
        if_valid = 1'b1;
        if_instr = 32'hFE000EE3;
        if_pc    = 32'h00003000;
        step();
        held_pc  = 32'h00003000;
        held_rd  = 5'd29;
        held_imm = 32'hFFFFFFFC;
        ex_ready = 1'b0;
        if_instr = 32'h00700293;
        if_pc    = 32'h00003004;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp%0d_if_ready", c), {31'd0, if_ready}, 32'd0);
            step();
            check($sformatf("bp%0d_ex_valid", c), {31'd0, ex_valid}, 32'd1);
            check($sformatf("bp%0d_ex_pc", c), ex_pc, held_pc);
            check($sformatf("bp%0d_ex_rd", c), {27'd0, ex_rd}, {27'd0, held_rd});
            check($sformatf("bp%0d_ex_imm", c), ex_imm, held_imm);
        end
        flush = 1'b1;
        #1;
        check("flush_if_ready", {31'd0, if_ready}, 32'd0);
        step();
        check("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
        idle_inputs();
        step();
        check("post_flush_idle", {31'd0, ex_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
